core_sequencer: RTL and testbench

- Multi-cycle control FSM for the tiny RISC-V core.
- Sequences fetch, execute and memory phases.
- Owns the single shared memory port, muxing instruction fetch and data load/store onto it.
- Drives the program-counter update enable and branch select into the PC/branch datapath; keeps a retired-instruction count.

---
 rtl/tiny_riscv_pkg.sv | 34 +++
 rtl/bus_watchdog.sv | 33 +++
 rtl/core_sequencer.sv | 143 ++++++++++++++
 tb/tb_core_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_riscv_pkg.sv
// Shared types for the tiny RISC-V core: sequencer states, trap causes and the
// per-cycle control bundle driven by the core sequencer.
package tiny_riscv_pkg;

  localparam logic [1:0] TRAP_NONE             = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL          = 2'd1;
  localparam logic [1:0] TRAP_MISALIGNED_FETCH = 2'd2;
  localparam logic [1:0] TRAP_BUS_TIMEOUT      = 2'd3;

  typedef enum logic [1:0] {
    STATE_FETCH,
    STATE_EXECUTE,
    STATE_MEMORY,
    STATE_TRAP
  } sequencer_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE             = TRAP_NONE,
    CAUSE_ILLEGAL          = TRAP_ILLEGAL,
    CAUSE_MISALIGNED_FETCH = TRAP_MISALIGNED_FETCH,
    CAUSE_BUS_TIMEOUT      = TRAP_BUS_TIMEOUT
  } trap_cause_t;

  typedef struct packed {
    logic mem_request;
    logic mem_write;
    logic instruction_write_enable;
    logic register_write_enable;
    logic program_counter_enable;
    logic branch;
    logic halted;
  } control_t;

endpackage

// File: rtl/bus_watchdog.sv
// Counts consecutive stalled memory-request cycles and flags a bus timeout.
// Present only when CORE_SEQUENCER_BUS_TIMEOUT_EN is defined.
`ifdef CORE_SEQUENCER_BUS_TIMEOUT_EN
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic request,
  input  logic ready,
  output logic timeout
);

  localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_STALL = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [COUNT_WIDTH-1:0] stall_count;

  // Fires on the limit-th stalled cycle; a ready on that same cycle wins.
  assign timeout = request && !ready && (stall_count == LAST_STALL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (!request || ready || timeout) begin
      stall_count <= '0;
    end else begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/EXECUTE/MEMORY/TRAP sequencer owning the shared memory port.
// Define CORE_SEQUENCER_BUS_TIMEOUT_EN to add the bus watchdog (trap cause 3).
module core_sequencer
  import tiny_riscv_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] program_counter,
  input  logic [ADDRESS_WIDTH-1:0] data_address,
  input  logic                     is_load,
  input  logic                     is_store,
  input  logic                     writes_register,
  input  logic                     branch_taken,
  input  logic                     illegal_instruction,
  input  logic                     mem_ready,
  output logic                     mem_request,
  output logic                     mem_write,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     instruction_write_enable,
  output logic                     register_write_enable,
  output logic                     program_counter_enable,
  output logic                     branch,
  output logic                     halted,
  output logic [1:0]               trap_cause,
  output logic [31:0]              retired_count
);

  sequencer_state_t         state, next_state;
  trap_cause_t              cause_q, cause_next;
  logic [31:0]              retired_q;
  control_t                 control, gated;
  logic [ADDRESS_WIDTH-1:0] address_raw;
  logic                     bus_active;
  logic                     timeout;

  // Derived from state alone so the watchdog never loops back through the FSM logic.
  assign bus_active = (state == STATE_FETCH && program_counter[1:0] == 2'b00)
                   || (state == STATE_MEMORY);

`ifdef CORE_SEQUENCER_BUS_TIMEOUT_EN
  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_watchdog (
    .clock  (clock),
    .reset  (reset),
    .request(bus_active),
    .ready  (mem_ready),
    .timeout(timeout)
  );
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    control     = '0;
    address_raw = '0;
    next_state  = state;
    cause_next  = cause_q;
    unique case (state)
      STATE_FETCH: begin
        if (program_counter[1:0] != 2'b00) begin
          next_state = STATE_TRAP;
          cause_next = CAUSE_MISALIGNED_FETCH;
        end else begin
          control.mem_request = bus_active;
          address_raw         = program_counter;
          if (timeout) begin
            next_state = STATE_TRAP;
            cause_next = CAUSE_BUS_TIMEOUT;
          end else if (mem_ready) begin
            control.instruction_write_enable = 1'b1;
            next_state                       = STATE_EXECUTE;
          end
        end
      end
      STATE_EXECUTE: begin
        if (illegal_instruction) begin
          next_state = STATE_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else if (is_load || is_store) begin
          next_state = STATE_MEMORY;
        end else begin
          control.program_counter_enable = 1'b1;
          control.branch                 = branch_taken;
          control.register_write_enable  = writes_register;
          next_state                     = STATE_FETCH;
        end
      end
      STATE_MEMORY: begin
        control.mem_request = bus_active;
        control.mem_write   = is_store;
        address_raw         = data_address;
        if (timeout) begin
          next_state = STATE_TRAP;
          cause_next = CAUSE_BUS_TIMEOUT;
        end else if (mem_ready) begin
          control.program_counter_enable = 1'b1;
          control.register_write_enable  = is_load;
          next_state                     = STATE_FETCH;
        end
      end
      STATE_TRAP: begin
        control.halted = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= STATE_FETCH;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state   <= next_state;
      cause_q <= cause_next;
      if (control.program_counter_enable) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  // NOTE: reset masks the combinational outputs too, so a request in flight drops at once.
  assign gated       = reset ? '0 : control;
  assign mem_address = reset ? '0 : address_raw;

  assign mem_request              = gated.mem_request;
  assign mem_write                = gated.mem_write;
  assign instruction_write_enable = gated.instruction_write_enable;
  assign register_write_enable    = gated.register_write_enable;
  assign program_counter_enable   = gated.program_counter_enable;
  assign branch                   = gated.branch;
  assign halted                   = gated.halted;
  assign trap_cause               = cause_q;
  assign retired_count            = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed phases plus randomized
// instruction streams checked against a per-instruction cycle model.
module tb_core_sequencer;

  localparam int AW = 32;
  localparam int TO = 15;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] program_counter;
  logic [AW-1:0] data_address;
  logic          is_load;
  logic          is_store;
  logic          writes_register;
  logic          branch_taken;
  logic          illegal_instruction;
  logic          mem_ready;
  logic          mem_request;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic          instruction_write_enable;
  logic          register_write_enable;
  logic          program_counter_enable;
  logic          branch;
  logic          halted;
  logic [1:0]    trap_cause;
  logic [31:0]   retired_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_retired = '0;

  core_sequencer #(
    .ADDRESS_WIDTH (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .program_counter         (program_counter),
    .data_address            (data_address),
    .is_load                 (is_load),
    .is_store                (is_store),
    .writes_register         (writes_register),
    .branch_taken            (branch_taken),
    .illegal_instruction     (illegal_instruction),
    .mem_ready               (mem_ready),
    .mem_request             (mem_request),
    .mem_write               (mem_write),
    .mem_address             (mem_address),
    .instruction_write_enable(instruction_write_enable),
    .register_write_enable   (register_write_enable),
    .program_counter_enable  (program_counter_enable),
    .branch                  (branch),
    .halted                  (halted),
    .trap_cause              (trap_cause),
    .retired_count           (retired_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic expect_outputs(input string tag, input logic req, input logic wr,
                                input logic [AW-1:0] addr, input logic iwe, input logic rwe,
                                input logic pce, input logic br, input logic hlt);
    check({tag, ".mem_request"}, mem_request, req);
    check({tag, ".mem_write"}, mem_write, wr);
    if (req) check({tag, ".mem_address"}, mem_address, addr);
    check({tag, ".instruction_write_enable"}, instruction_write_enable, iwe);
    check({tag, ".register_write_enable"}, register_write_enable, rwe);
    check({tag, ".program_counter_enable"}, program_counter_enable, pce);
    check({tag, ".branch"}, branch, br);
    check({tag, ".halted"}, halted, hlt);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic randomize_decoder();
    is_load             = 1'($urandom);
    is_store            = 1'($urandom);
    writes_register     = 1'($urandom);
    branch_taken        = 1'($urandom);
    illegal_instruction = 1'($urandom);
  endtask

  // Holds reset for a cycle with junk inputs; everything must read zero meanwhile.
  task automatic apply_reset();
    reset = 1'b1;
    randomize_decoder();
    mem_ready       = 1'b1;
    program_counter = $urandom;
    data_address    = $urandom;
    #1;
    expect_outputs("reset", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.trap_cause", trap_cause, 2'd0);
    check("reset.retired_count", retired_count, 32'd0);
    next_cycle();
    reset       = 1'b0;
    exp_retired = '0;
  endtask

  // Fetch phase: `waits` stall cycles, then ready; decoder inputs are noise here.
  task automatic do_fetch(input logic [AW-1:0] pc, input int waits);
    for (int w = 0; w <= waits; w++) begin
      program_counter = pc;
      data_address    = $urandom;
      mem_ready       = (w == waits);
      randomize_decoder();
      @(negedge clock);
      if (w == 0) begin
        check("fetch.retired_count", retired_count, exp_retired);
        check("fetch.trap_cause", trap_cause, 2'd0);
      end
      expect_outputs("fetch", 1'b1, 1'b0, pc, (w == waits), 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();
    end
  endtask

  // kind: 0 = ALU/branch, 1 = load, 2 = store.
  task automatic run_instruction(input int kind, input logic [AW-1:0] pc, input logic [AW-1:0] daddr,
                                 input logic wr_reg, input logic taken,
                                 input int fetch_wait, input int mem_wait);
    logic mem_op;
    logic load;
    mem_op = (kind != 0);
    load   = (kind == 1);
    do_fetch(pc, fetch_wait);
    illegal_instruction = 1'b0;
    is_load             = load;
    is_store            = (kind == 2);
    writes_register     = wr_reg;
    branch_taken        = taken;
    data_address        = daddr;
    mem_ready           = 1'($urandom);
    @(negedge clock);
    expect_outputs("execute", 1'b0, 1'b0, '0, 1'b0, mem_op ? 1'b0 : wr_reg,
                   !mem_op, mem_op ? 1'b0 : taken, 1'b0);
    next_cycle();
    if (!mem_op) exp_retired++;
    if (mem_op) begin
      for (int w = 0; w <= mem_wait; w++) begin
        mem_ready       = (w == mem_wait);
        writes_register = 1'($urandom);
        branch_taken    = 1'($urandom);
        program_counter = $urandom;
        @(negedge clock);
        expect_outputs("memory", 1'b1, (kind == 2), daddr, 1'b0,
                       (w == mem_wait) && load, (w == mem_wait), 1'b0, 1'b0);
        next_cycle();
      end
      exp_retired++;
    end
  endtask

  initial begin
    reset = 1'b1;
    program_counter = '0; data_address = '0; mem_ready = 1'b0;
    is_load = 1'b0; is_store = 1'b0; writes_register = 1'b0;
    branch_taken = 1'b0; illegal_instruction = 1'b0;

    apply_reset();

    // Zero-wait ALU at 0x0, taken branch without rd write, slow load, store.
    run_instruction(0, 32'h0000_0000, '0, 1'b1, 1'b0, 0, 0);
    run_instruction(0, 32'h0000_0004, '0, 1'b0, 1'b1, 0, 0);
    run_instruction(1, 32'h0000_0008, 32'h0000_0100, 1'b0, 1'b0, 0, 3);
    run_instruction(2, 32'h0000_000C, 32'h0000_0204, 1'b1, 1'b1, 1, 0);

    for (int i = 0; i < 40; i++) begin
      run_instruction(int'($urandom_range(2, 0)), $urandom & 32'hFFFF_FFFC, $urandom,
                      1'($urandom), 1'($urandom),
                      int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
    end

    // Illegal together with is_load: trap wins and the core stays halted.
    do_fetch(32'h0000_0010, 0);
    illegal_instruction = 1'b1; is_load = 1'b1; writes_register = 1'b1;
    branch_taken = 1'b1; mem_ready = 1'b1;
    @(negedge clock);
    expect_outputs("illegal", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      randomize_decoder();
      mem_ready       = 1'($urandom);
      program_counter = $urandom & 32'hFFFF_FFFC;
      @(negedge clock);
      expect_outputs("trap_illegal", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("trap_illegal.cause", trap_cause, 2'd1);
      check("trap_illegal.retired_count", retired_count, exp_retired);
      next_cycle();
    end

    // Misaligned fetch address.
    apply_reset();
    program_counter = 32'h0000_0006; mem_ready = 1'b1;
    @(negedge clock);
    expect_outputs("misaligned", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    @(negedge clock);
    expect_outputs("trap_misaligned", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("trap_misaligned.cause", trap_cause, 2'd2);

    // Reset asserted in the middle of a stalled load.
    next_cycle();
    apply_reset();
    run_instruction(0, 32'h0000_0020, '0, 1'b1, 1'b0, 0, 0);
    do_fetch(32'h0000_0024, 0);
    illegal_instruction = 1'b0; is_load = 1'b1; is_store = 1'b0;
    data_address = 32'h0000_0200; mem_ready = 1'b0;
    @(negedge clock);
    expect_outputs("abort.execute", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    @(negedge clock);
    expect_outputs("abort.memory", 1'b1, 1'b0, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    expect_outputs("abort.reset", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort.retired_count", retired_count, 32'd0);
    next_cycle();
    reset = 1'b0;
    exp_retired = '0;
    run_instruction(1, 32'h0000_0040, 32'h0000_0300, 1'b0, 1'b0, 0, 0);

`ifdef CORE_SEQUENCER_BUS_TIMEOUT_EN
    // Ready never arrives: trap cause 3 after TO request cycles.
    apply_reset();
    for (int c = 0; c < TO; c++) begin
      program_counter = 32'h0000_0080; mem_ready = 1'b0;
      @(negedge clock);
      expect_outputs("timeout.wait", 1'b1, 1'b0, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();
    end
    @(negedge clock);
    expect_outputs("timeout.trap", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("timeout.cause", trap_cause, 2'd3);
    next_cycle();
    // Ready on the limit cycle completes normally, for fetch and for a store.
    apply_reset();
    run_instruction(0, 32'h0000_0084, '0, 1'b1, 1'b0, TO - 1, 0);
    run_instruction(2, 32'h0000_0088, 32'h0000_0400, 1'b0, 1'b0, 0, TO - 1);
`else
    // Without the watchdog the core waits indefinitely.
    run_instruction(0, 32'h0000_0084, '0, 1'b1, 1'b0, 40, 0);
    run_instruction(1, 32'h0000_0088, 32'h0000_0400, 1'b0, 1'b0, 0, 40);
`endif
    @(negedge clock);
    check("final.retired_count", retired_count, exp_retired);
    check("final.trap_cause", trap_cause, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
